// File: rtl/aurora_pkg.sv
// Shared Aurora TX types: channel-init ordered-set requests
// and lane slot kinds presented to the lane encoder.
package aurora_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SP   = 2'd1,
    I    = 2'd2,
    VER  = 2'd3
  } ordered_sets_e;

  localparam logic [2:0] K_IDLE = 3'd0;
  localparam logic [2:0] K_SP   = 3'd1;
  localparam logic [2:0] K_VER  = 3'd2;
  localparam logic [2:0] K_CC   = 3'd3;
  localparam logic [2:0] K_SCP  = 3'd4;
  localparam logic [2:0] K_DATA = 3'd5;
  localparam logic [2:0] K_ECP  = 3'd6;

endpackage

// File: rtl/tx_scheduler_if.sv
// Bundle between channel-init/user TX stream and the lane encoder.
// master = upstream driver, slave = tx_scheduler.
interface tx_scheduler_if #(
  parameter int DATA_W = 16
);
  import aurora_pkg::*;

  ordered_sets_e     ordered_sets;
  logic              init_finished;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [2:0]        tx_kind;
  logic [DATA_W-1:0] tx_data;

  modport master (
    output ordered_sets,
    output init_finished,
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready,
    input  tx_kind,
    input  tx_data
  );

  modport slave (
    input  ordered_sets,
    input  init_finished,
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready,
    output tx_kind,
    output tx_data
  );

endinterface

// File: rtl/tx_scheduler.sv
// Per-lane TX slot scheduler: init ordered sets, framed data, CC bursts.
// Ports: clk, rst_n (async low), bus (tx_scheduler_if.slave):
//   in  ordered_sets, init_finished, s_data/s_valid/s_last
//   out s_ready (comb), tx_kind/tx_data (registered)
// Macro AURORA_CC_INSERT_EN enables periodic CC bursts.
module tx_scheduler
  import aurora_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  tx_scheduler_if.slave  bus
);

  if (CC_LEN < 1 || CC_PERIOD <= CC_LEN + 2) begin : g_bad_cfg
    $error("tx_scheduler: CC_PERIOD must exceed CC_LEN+2, CC_LEN >= 1");
  end

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_DATA,
    ST_EOF,
    ST_CC
  } state_e;

  state_e            state_q;
  state_e            state_d;
  state_e            eff_state;
  logic [2:0]        kind_q;
  logic [2:0]        kind_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic              cc_due;
  logic              init_ok;
  logic              accept;
  logic [2:0]        os_kind;

  assign init_ok = bus.init_finished;

`ifdef AURORA_CC_INSERT_EN
  localparam int CW = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int BW = (CC_LEN > 1) ? $clog2(CC_LEN) : 1;

  logic [CW-1:0] cc_cnt_q;
  logic [CW-1:0] cc_cnt_d;
  logic [BW-1:0] cc_idx_q;
  logic [BW-1:0] cc_idx_d;
  state_e        ret_q;
  state_e        ret_d;
  logic          cc_done;

  assign cc_due   = (cc_cnt_q == CW'(CC_PERIOD - 1));
  assign cc_done  = (cc_idx_q == BW'(CC_LEN - 1));
  assign cc_cnt_d = cc_due ? '0 : cc_cnt_q + CW'(1);

  // On the last CC slot the scheduler acts as the return state,
  // so the slot after the burst is not wasted.
  always_comb begin
    eff_state = state_q;
    if (state_q == ST_CC && cc_done) begin
      eff_state = init_ok ? ret_q : ST_INIT;
    end
  end
`else
  assign cc_due = 1'b0;

  always_comb begin
    eff_state = state_q;
  end
`endif

  assign bus.s_ready = init_ok && !cc_due
                     && (eff_state == ST_DATA);

  assign accept  = bus.s_valid && bus.s_ready;
  assign bus.tx_kind = kind_q;
  assign bus.tx_data = data_q;

  always_comb begin
    os_kind = K_IDLE;
    unique case (1'b1)
      bus.ordered_sets == SP:  os_kind = K_SP;
      bus.ordered_sets == VER: os_kind = K_VER;
      default:                 os_kind = K_IDLE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    kind_d  = K_IDLE;
    data_d  = '0;
`ifdef AURORA_CC_INSERT_EN
    ret_d    = ret_q;
    cc_idx_d = cc_idx_q;
    if (cc_due && state_q != ST_CC) begin
      ret_d    = init_ok ? state_q : ST_INIT;
      state_d  = ST_CC;
      cc_idx_d = '0;
      kind_d   = K_CC;
    end else if (state_q == ST_CC && !cc_done) begin
      kind_d   = K_CC;
      cc_idx_d = cc_idx_q + BW'(1);
      if (!init_ok) begin
        ret_d = ST_INIT;
      end
    end else
`endif
    if (!init_ok) begin
      state_d = ST_INIT;
      kind_d  = os_kind;
    end else begin
      unique case (eff_state)
        ST_INIT: begin
          state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (bus.s_valid) begin
            kind_d  = K_SCP;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          state_d = ST_DATA;
          if (accept) begin
            kind_d = K_DATA;
            data_d = bus.s_data;
            if (bus.s_last) begin
              state_d = ST_EOF;
            end
          end
        end
        ST_EOF: begin
          kind_d  = K_ECP;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      kind_q  <= K_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      data_q  <= data_d;
    end
  end

`ifdef AURORA_CC_INSERT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_cnt_q <= '0;
      cc_idx_q <= '0;
      ret_q    <= ST_INIT;
    end else begin
      cc_cnt_q <= cc_cnt_d;
      cc_idx_q <= cc_idx_d;
      ret_q    <= ret_d;
    end
  end
`endif

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler: vector tables,
// hand-written CC/init-drop sequences and a random model run.
module tb_tx_scheduler;
  import aurora_pkg::*;

  localparam int DW = 16;
  localparam int P  = 20;
  localparam int L  = 3;

  typedef struct {
    logic          fi;
    ordered_sets_e os;
    logic          v;
    logic          l;
    logic [DW-1:0] d;
    logic [2:0]    ek;
    logic [DW-1:0] ed;
    logic          er;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  tx_scheduler_if #(.DATA_W(DW)) bus ();

  tx_scheduler #(
    .DATA_W(DW),
    .CC_PERIOD(P),
    .CC_LEN(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic vec_t mk(
    input logic fi, input ordered_sets_e os,
    input logic v, input logic l, input logic [DW-1:0] d,
    input logic [2:0] ek, input logic [DW-1:0] ed,
    input logic er);
    vec_t r;
    r.fi = fi; r.os = os; r.v = v; r.l = l; r.d = d;
    r.ek = ek; r.ed = ed; r.er = er;
    return r;
  endfunction

  // CC slots appear after edges e with e mod P < L, from edge P on.
  function automatic bit cc_slot(input int e);
`ifdef AURORA_CC_INSERT_EN
    return (e >= P) && ((e % P) < L);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fi, input ordered_sets_e os,
                       input logic v, input logic l,
                       input logic [DW-1:0] d,
                       output logic r, output logic [2:0] k,
                       output logic [DW-1:0] od);
    bus.init_finished = fi;
    bus.ordered_sets  = os;
    bus.s_valid       = v;
    bus.s_last        = l;
    bus.s_data        = d;
    #1;
    r = bus.s_ready;
    @(posedge clk);
    #1;
    k  = bus.tx_kind;
    od = bus.tx_data;
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.init_finished = 1'b0;
    bus.ordered_sets  = NONE;
    bus.s_valid       = 1'b0;
    bus.s_last        = 1'b0;
    bus.s_data        = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vecs(input string tag);
    logic          r;
    logic [2:0]    k;
    logic [DW-1:0] od;
    foreach (vq[n]) begin
      drive(vq[n].fi, vq[n].os, vq[n].v, vq[n].l, vq[n].d,
            r, k, od);
      chk($sformatf("%s[%0d].ready", tag, n), 32'(r), 32'(vq[n].er));
      chk($sformatf("%s[%0d].kind", tag, n), 32'(k), 32'(vq[n].ek));
      chk($sformatf("%s[%0d].data", tag, n), 32'(od), 32'(vq[n].ed));
    end
  endtask

  initial begin : main
    logic          r;
    logic [2:0]    k;
    logic [DW-1:0] od;
    logic [2:0]    gk[0:40];
    logic [DW-1:0] gd[0:40];
    logic [2:0]    ek[0:9];
    logic [DW-1:0] ed[0:9];
    logic [DW-1:0] beats[0:3];
    int            bi;
    int            rlow;
    int            wend;
    int            ph;
    int            down;
    logic          fi;
    ordered_sets_e os;
    logic          v;
    logic          l;
    logic [DW-1:0] d;
    logic [2:0]    xk;
    logic [DW-1:0] xd;
    logic          xr;

    // Reset values
    rst_n = 1'b0;
    bus.init_finished = 1'b0;
    bus.ordered_sets  = NONE;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    #2;
    chk("rst.kind", 32'(bus.tx_kind), 32'(K_IDLE));
    chk("rst.data", 32'(bus.tx_data), 32'h0);
    chk("rst.ready", 32'(bus.s_ready), 32'h0);

    // Table 1: init ordered sets, then a 4-beat frame
    do_reset();
    vq = {};
    vq.push_back(mk(0, SP,   0, 0, 16'h0,  K_SP,   16'h0,  0));
    vq.push_back(mk(0, VER,  0, 0, 16'h0,  K_VER,  16'h0,  0));
    vq.push_back(mk(0, I,    0, 0, 16'h0,  K_IDLE, 16'h0,  0));
    vq.push_back(mk(0, NONE, 1, 0, 16'h55, K_IDLE, 16'h0,  0));
    vq.push_back(mk(1, NONE, 0, 0, 16'h0,  K_IDLE, 16'h0,  0));
    vq.push_back(mk(1, NONE, 1, 0, 16'hA1, K_SCP,  16'h0,  0));
    vq.push_back(mk(1, NONE, 1, 0, 16'hA1, K_DATA, 16'hA1, 1));
    vq.push_back(mk(1, NONE, 1, 0, 16'hA2, K_DATA, 16'hA2, 1));
    vq.push_back(mk(1, NONE, 1, 0, 16'hA3, K_DATA, 16'hA3, 1));
    vq.push_back(mk(1, NONE, 1, 1, 16'hA4, K_DATA, 16'hA4, 1));
    vq.push_back(mk(1, NONE, 0, 0, 16'h0,  K_ECP,  16'h0,  0));
    vq.push_back(mk(1, NONE, 0, 0, 16'h0,  K_IDLE, 16'h0,  0));
    vq.push_back(mk(1, NONE, 1, 0, 16'hB1, K_SCP,  16'h0,  0));
    run_vecs("init_frame");

    // Table 2: init_finished drops after beat 2, then re-init
    do_reset();
    vq = {};
    vq.push_back(mk(1, NONE, 0, 0, 16'h0,  K_IDLE, 16'h0,  0));
    vq.push_back(mk(1, NONE, 1, 0, 16'hA1, K_SCP,  16'h0,  0));
    vq.push_back(mk(1, NONE, 1, 0, 16'hA1, K_DATA, 16'hA1, 1));
    vq.push_back(mk(1, NONE, 1, 0, 16'hA2, K_DATA, 16'hA2, 1));
    vq.push_back(mk(0, SP,   1, 0, 16'hA3, K_SP,   16'h0,  0));
    vq.push_back(mk(0, VER,  1, 0, 16'hA3, K_VER,  16'h0,  0));
    vq.push_back(mk(1, NONE, 1, 0, 16'hB1, K_IDLE, 16'h0,  0));
    vq.push_back(mk(1, NONE, 1, 0, 16'hB1, K_SCP,  16'h0,  0));
    vq.push_back(mk(1, NONE, 1, 0, 16'hB1, K_DATA, 16'hB1, 1));
    vq.push_back(mk(1, NONE, 1, 0, 16'hB2, K_DATA, 16'hB2, 1));
    run_vecs("init_drop");

    // Async reset mid-frame clears outputs immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.kind", 32'(bus.tx_kind), 32'(K_IDLE));
    chk("async_rst.data", 32'(bus.tx_data), 32'h0);
    chk("async_rst.ready", 32'(bus.s_ready), 32'h0);

    // CC timing on an idle link
    do_reset();
    for (int e = 1; e <= 45; e++) begin
      drive(1'b1, NONE, 1'b0, 1'b0, '0, r, k, od);
      chk($sformatf("cc_idle.kind@%0d", e), 32'(k),
          32'(cc_slot(e) ? K_CC : K_IDLE));
      chk($sformatf("cc_idle.ready@%0d", e), 32'(r), 32'h0);
    end

    // Frame with a CC burst right after beat 2 is accepted
    do_reset();
    beats[0] = 16'hA1; beats[1] = 16'hA2;
    beats[2] = 16'hA3; beats[3] = 16'hA4;
    bi = 0;
    rlow = 0;
`ifdef AURORA_CC_INSERT_EN
    wend = 24;
    ek[0] = K_SCP;  ek[1] = K_DATA; ek[2] = K_DATA;
    ek[3] = K_CC;   ek[4] = K_CC;   ek[5] = K_CC;
    ek[6] = K_DATA; ek[7] = K_DATA; ek[8] = K_ECP;
    ek[9] = K_IDLE;
    ed[0] = 0;      ed[1] = 16'hA1; ed[2] = 16'hA2;
    ed[3] = 0;      ed[4] = 0;      ed[5] = 0;
    ed[6] = 16'hA3; ed[7] = 16'hA4; ed[8] = 0;
    ed[9] = 0;
`else
    wend = 21;
    ek[0] = K_SCP;  ek[1] = K_DATA; ek[2] = K_DATA;
    ek[3] = K_DATA; ek[4] = K_DATA; ek[5] = K_ECP;
    ek[6] = K_IDLE; ek[7] = K_IDLE; ek[8] = K_IDLE;
    ek[9] = K_IDLE;
    ed[0] = 0;      ed[1] = 16'hA1; ed[2] = 16'hA2;
    ed[3] = 16'hA3; ed[4] = 16'hA4; ed[5] = 0;
    ed[6] = 0;      ed[7] = 0;      ed[8] = 0;
    ed[9] = 0;
`endif
    for (int c = 1; c <= 28; c++) begin
      v = (c >= 17) && (bi < 4);
      drive(1'b1, NONE, v, v && (bi == 3),
            v ? beats[bi] : '0, r, k, od);
      if (c >= 18 && c <= wend && !r) rlow++;
      if (r && v) bi++;
      gk[c] = k;
      gd[c] = od;
    end
    for (int n = 0; n < 10; n++) begin
      chk($sformatf("cc_frame.kind@%0d", n + 17),
          32'(gk[n + 17]), 32'(ek[n]));
      chk($sformatf("cc_frame.data@%0d", n + 17),
          32'(gd[n + 17]), 32'(ed[n]));
    end
`ifdef AURORA_CC_INSERT_EN
    chk("cc_frame.ready_low", 32'(rlow), 32'd3);
`else
    chk("cc_frame.ready_low", 32'(rlow), 32'd0);
`endif
    chk("cc_frame.beats_taken", 32'(bi), 32'd4);

    // Random traffic against a phase-level reference model:
    // 0 link down, 1 between frames, 2 in frame, 3 ECP owed.
    do_reset();
    ph = 0;
    down = 4;
    v = 1'b0;
    l = 1'b0;
    d = 16'(($urandom));
    for (int e = 1; e <= 400; e++) begin
      if (down > 0) begin
        fi = 1'b0;
        down--;
      end else begin
        fi = 1'b1;
        if ($urandom_range(0, 39) == 0) down = $urandom_range(1, 6);
      end
      os = ordered_sets_e'($urandom_range(0, 3));
      v  = ($urandom_range(0, 3) != 0);
      xk = K_IDLE;
      xd = '0;
      xr = !cc_slot(e) && fi && (ph == 2);
      if (cc_slot(e)) begin
        xk = K_CC;
        if (!fi) ph = 0;
      end else if (!fi) begin
        xk = (os == SP) ? K_SP : (os == VER) ? K_VER : K_IDLE;
        ph = 0;
      end else begin
        case (ph)
          0: ph = 1;
          1: if (v) begin xk = K_SCP; ph = 2; end
          2: if (v) begin
               xk = K_DATA;
               xd = d;
               if (l) ph = 3;
             end
          default: begin xk = K_ECP; ph = 1; end
        endcase
      end
      drive(fi, os, v, l, d, r, k, od);
      chk($sformatf("rand.ready@%0d", e), 32'(r), 32'(xr));
      chk($sformatf("rand.kind@%0d", e), 32'(k), 32'(xk));
      chk($sformatf("rand.data@%0d", e), 32'(od), 32'(xd));
      if (r && v) begin
        d = 16'($urandom);
        l = ($urandom_range(0, 3) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
